// File: rtl/sd_pkg.sv
// Shared definitions for the SD CMD-line serialiser: frame geometry,
// FSM state encoding and the single-step CRC7 update.
package sd_pkg;

   localparam int SD_CMD_FRAME_BITS = 48;
   localparam int SD_CMD_HEAD_BITS  = 40;
   localparam int CRC_W             = 7;
   localparam logic [CRC_W-1:0] SD_CRC7_POLY = 7'h09;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_ARM,
      ST_SHIFT,
      ST_GAP,
      ST_FIN
   } sd_cmd_state_t;

   // One serial step of x^7 + x^3 + 1, data bit fed MSB first.
   function automatic logic [CRC_W-1:0] crc7_next(input logic [CRC_W-1:0] crc,
                                                  input logic din);
      logic fb;
      fb = din ^ crc[CRC_W-1];
      return {crc[CRC_W-2:0], 1'b0} ^ (fb ? SD_CRC7_POLY : {CRC_W{1'b0}});
   endfunction

endpackage

// File: rtl/sd_crc7.sv
// Serial CRC7 LFSR; clr wins over en, value holds when neither is set.
module sd_crc7
   import sd_pkg::*;
(
   input  logic             clk,
   input  logic             rst_n,
   input  logic             clr,
   input  logic             en,
   input  logic             din,
   output logic [CRC_W-1:0] crc
);

   logic [CRC_W-1:0] crc_reg;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         crc_reg <= '0;
      end else if (clr) begin
         crc_reg <= '0;
      end else if (en) begin
         crc_reg <= crc7_next(crc_reg, din);
      end
   end

   assign crc = crc_reg;

endmodule

// File: rtl/sd_cmd_sender.sv
// Serialises a 48-bit SD command frame (head + CRC7 + end bit) onto the
// CMD pad, paced by bit_en, followed by GAP_BITS idle-high bit periods.
module sd_cmd_sender
   import sd_pkg::*;
#(
   parameter int GAP_BITS = 8
)
(
   input  logic             clk,
   input  logic             rst_n,
   input  logic             bit_en,
   input  logic             req_valid,
   output logic             req_ready,
   input  logic [5:0]       req_index,
   input  logic [31:0]      req_arg,
   input  logic             abort,
   output logic             cmd_out,
   output logic             cmd_oe,
   output logic             busy,
   output logic             done,
   output logic [CRC_W-1:0] crc_last
);

   localparam int GAP_CW = $clog2(GAP_BITS + 1);
   localparam int CNT_W  = (GAP_CW > 6) ? GAP_CW : 6;
   localparam logic [CNT_W-1:0] LAST_HEAD = CNT_W'(SD_CMD_HEAD_BITS - 1);
   localparam logic [CNT_W-1:0] LAST_BIT  = CNT_W'(SD_CMD_FRAME_BITS - 1);
   localparam logic [CNT_W-1:0] CRC_MSB_N = CNT_W'(SD_CMD_FRAME_BITS - 2);
   localparam logic [CNT_W-1:0] GAP_LAST  = CNT_W'(GAP_BITS - 1);

   sd_cmd_state_t                state_reg, state_next;
   logic [SD_CMD_HEAD_BITS-1:0]  head_reg, head_next;
   logic [CNT_W-1:0]             cnt_reg, cnt_next;
   logic                         cmd_out_reg, cmd_out_next;
   logic                         cmd_oe_reg, cmd_oe_next;
   logic [CRC_W-1:0]             crc_last_reg, crc_last_next;
   logic                         crc_clr, crc_en;
   logic [CRC_W-1:0]             crc;
   logic [2:0]                   crc_idx;

   sd_crc7 u_crc7 (
      .clk   (clk),
      .rst_n (rst_n),
      .clr   (crc_clr),
      .en    (crc_en),
      .din   (head_reg[SD_CMD_HEAD_BITS-1]),
      .crc   (crc)
   );

   // Bits 40..46 carry the CRC MSB first: bit n selects crc[46-n].
   assign crc_idx = 3'(CRC_MSB_N - cnt_reg);

   always_comb begin
      state_next    = state_reg;
      head_next     = head_reg;
      cnt_next      = cnt_reg;
      cmd_out_next  = cmd_out_reg;
      cmd_oe_next   = cmd_oe_reg;
      crc_last_next = crc_last_reg;
      crc_clr       = 1'b0;
      crc_en        = 1'b0;
      if (abort) begin
         state_next   = ST_IDLE;
         cmd_oe_next  = 1'b0;
         cmd_out_next = 1'b1;
         cnt_next     = '0;
      end else begin
         case (state_reg)
            ST_IDLE: begin
               if (req_valid) begin
                  head_next  = {1'b0, 1'b1, req_index, req_arg};
                  crc_clr    = 1'b1;
                  state_next = ST_ARM;
               end
            end
            ST_ARM: begin
               if (bit_en) begin
                  cmd_oe_next  = 1'b1;
                  cmd_out_next = head_reg[SD_CMD_HEAD_BITS-1];
                  head_next    = {head_reg[SD_CMD_HEAD_BITS-2:0], 1'b0};
                  crc_en       = 1'b1;
                  cnt_next     = CNT_W'(1);
                  state_next   = ST_SHIFT;
               end
            end
            ST_SHIFT: begin
               if (bit_en) begin
                  cnt_next = cnt_reg + 1'b1;
                  if (cnt_reg <= LAST_HEAD) begin
                     cmd_out_next = head_reg[SD_CMD_HEAD_BITS-1];
                     head_next    = {head_reg[SD_CMD_HEAD_BITS-2:0], 1'b0};
                     crc_en       = 1'b1;
                  end else if (cnt_reg < LAST_BIT) begin
                     cmd_out_next = crc[crc_idx];
                  end else begin
                     cmd_out_next = 1'b1;
                     cnt_next     = '0;
                     state_next   = (GAP_BITS == 0) ? ST_FIN : ST_GAP;
                  end
               end
            end
            ST_GAP: begin
               if (bit_en) begin
                  if (cnt_reg == GAP_LAST) begin
                     cnt_next   = '0;
                     state_next = ST_FIN;
                  end else begin
                     cnt_next = cnt_reg + 1'b1;
                  end
               end
            end
            ST_FIN: begin
               cmd_oe_next   = 1'b0;
               crc_last_next = crc;
               state_next    = ST_IDLE;
            end
            default: begin
               state_next = ST_IDLE;
            end
         endcase
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_reg    <= ST_IDLE;
         head_reg     <= '0;
         cnt_reg      <= '0;
         cmd_out_reg  <= 1'b1;
         cmd_oe_reg   <= 1'b0;
         crc_last_reg <= '0;
      end else begin
         state_reg    <= state_next;
         head_reg     <= head_next;
         cnt_reg      <= cnt_next;
         cmd_out_reg  <= cmd_out_next;
         cmd_oe_reg   <= cmd_oe_next;
         crc_last_reg <= crc_last_next;
      end
   end

   assign req_ready = (state_reg == ST_IDLE) && !abort;
   assign busy      = (state_reg != ST_IDLE);
   assign done      = (state_reg == ST_FIN) && !abort;
   assign cmd_out   = cmd_out_reg;
   assign cmd_oe    = cmd_oe_reg;
   assign crc_last  = crc_last_reg;

endmodule

// File: tb/tb_sd_cmd_sender.sv
// Directed bench for sd_cmd_sender: known SD command frames with
// hand-computed CRC7, stalls, abort and mid-frame reset.
module tb_sd_cmd_sender;

   logic        clk;
   logic        rst_n;
   logic        bit_en;
   logic        req_valid;
   logic        req_ready;
   logic [5:0]  req_index;
   logic [31:0] req_arg;
   logic        abort;
   logic        cmd_out;
   logic        cmd_oe;
   logic        busy;
   logic        done;
   logic [6:0]  crc_last;

   int n_checks = 0;
   int n_errors = 0;
   bit be_hold  = 0;
   int div_cnt  = 0;

   sd_cmd_sender #(.GAP_BITS(8)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .bit_en    (bit_en),
      .req_valid (req_valid),
      .req_ready (req_ready),
      .req_index (req_index),
      .req_arg   (req_arg),
      .abort     (abort),
      .cmd_out   (cmd_out),
      .cmd_oe    (cmd_oe),
      .busy      (busy),
      .done      (done),
      .crc_last  (crc_last)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Bit-rate strobe: one clk in four, suppressible for stall tests.
   initial begin
      bit_en = 1'b0;
      forever begin
         @(negedge clk);
         div_cnt++;
         bit_en = !be_hold && (div_cnt % 4 == 0);
      end
   end

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   // Issue one command and follow it to done, abort or reset.
   // hold_at/abort_at/rst_at are strobe counts (0 = not used).
   task automatic send_cmd(input logic [5:0] idx, input logic [31:0] arg,
                           input logic [47:0] exp_frame, input logic [6:0] exp_crc,
                           input int hold_at, input int abort_at, input int rst_at,
                           input bit chain, input logic [5:0] nidx, input logic [31:0] narg);
      int          nstb     = 0;
      int          rdy_bad  = 0;
      int          hold_bad = 0;
      int          dn_cnt   = 0;
      int          guard;
      bit          got_done = 0;
      bit          be;
      logic        o_hold, e_hold;
      logic [47:0] frame    = '0;

      if (!req_valid) begin
         @(negedge clk);
         req_valid = 1'b1;
         req_index = idx;
         req_arg   = arg;
      end
      guard = 0;
      while (!req_ready && guard < 2000) begin
         @(negedge clk);
         guard++;
      end
      check("handshake_wait", 64'(guard < 2000), 64'd1);
      @(posedge clk);
      #1;
      if (chain) begin
         req_index = nidx;
         req_arg   = narg;
      end else begin
         req_valid = 1'b0;
      end

      for (int cyc = 0; cyc < 3000; cyc++) begin
         @(posedge clk);
         be = bit_en && !abort;
         #1;
         if (be && cmd_oe) begin
            if (nstb < 48) frame = {frame[46:0], cmd_out};
            nstb++;
         end
         if (done) begin
            got_done = 1'b1;
            break;
         end
         if (req_ready) rdy_bad++;
         if (be && nstb == hold_at) begin
            be_hold = 1'b1;
            o_hold  = cmd_out;
            e_hold  = cmd_oe;
            repeat (100) begin
               @(posedge clk);
               #1;
               if (cmd_out !== o_hold || cmd_oe !== e_hold) hold_bad++;
            end
            be_hold = 1'b0;
            check("stall_line_stable", 64'(hold_bad), 64'd0);
         end
         if (be && nstb == abort_at) begin
            @(negedge clk);
            abort = 1'b1;
            @(posedge clk);
            #1;
            check("abort_oe", 64'(cmd_oe), 64'd0);
            check("abort_out", 64'(cmd_out), 64'd1);
            check("abort_busy", 64'(busy), 64'd0);
            abort = 1'b0;
            repeat (300) begin
               @(posedge clk);
               #1;
               if (done) dn_cnt++;
            end
            check("abort_no_done", 64'(dn_cnt), 64'd0);
            check("abort_crc_last", 64'(crc_last), 64'(exp_crc));
            $display("cmd%0d arg %h aborted after %0d bits", idx, arg, nstb);
            return;
         end
         if (be && nstb == rst_at) begin
            #2 rst_n = 1'b0;
            #1;
            check("rst_oe_async", 64'(cmd_oe), 64'd0);
            check("rst_out", 64'(cmd_out), 64'd1);
            check("rst_busy", 64'(busy), 64'd0);
            check("rst_ready", 64'(req_ready), 64'd1);
            check("rst_crc_last", 64'(crc_last), 64'd0);
            @(negedge clk);
            rst_n = 1'b1;
            $display("cmd%0d arg %h reset after %0d strobes", idx, arg, nstb);
            return;
         end
      end

      check("done_seen", 64'(got_done), 64'd1);
      check("frame_bits", 64'(frame), 64'(exp_frame));
      check("strobes_to_done", 64'(nstb), 64'd56);
      check("ready_low_in_frame", 64'(rdy_bad), 64'd0);
      @(posedge clk);
      #1;
      check("done_one_clk", 64'(done), 64'd0);
      check("oe_released", 64'(cmd_oe), 64'd0);
      check("ready_back", 64'(req_ready), 64'd1);
      check("crc_last", 64'(crc_last), 64'(exp_crc));
      $display("cmd%0d arg %h frame %h crc_last %h strobes %0d", idx, arg, frame, crc_last, nstb);
   endtask

   initial begin
      rst_n     = 1'b0;
      req_valid = 1'b0;
      req_index = '0;
      req_arg   = '0;
      abort     = 1'b0;
      repeat (3) @(negedge clk);
      check("reset_out", 64'(cmd_out), 64'd1);
      check("reset_oe", 64'(cmd_oe), 64'd0);
      check("reset_ready", 64'(req_ready), 64'd1);
      check("reset_busy", 64'(busy), 64'd0);
      check("reset_done", 64'(done), 64'd0);
      check("reset_crc_last", 64'(crc_last), 64'd0);
      rst_n = 1'b1;
      repeat (2) @(negedge clk);

      send_cmd(6'd0,  32'h0000_0000, 48'h40_0000_0000_95, 7'h4A, 0, 0, 0, 1'b0, 6'd0, 32'h0);
      send_cmd(6'd8,  32'h0000_01AA, 48'h48_0000_01AA_87, 7'h43, 0, 0, 0, 1'b0, 6'd0, 32'h0);
      send_cmd(6'd55, 32'h0000_0000, 48'h77_0000_0000_65, 7'h32, 0, 0, 0, 1'b1, 6'd41, 32'h4000_0000);
      send_cmd(6'd41, 32'h4000_0000, 48'h69_4000_0000_77, 7'h3B, 0, 0, 0, 1'b0, 6'd0, 32'h0);
      send_cmd(6'd0,  32'h0000_0000, 48'h40_0000_0000_95, 7'h4A, 20, 0, 0, 1'b0, 6'd0, 32'h0);
      send_cmd(6'd17, 32'h0000_0000, 48'h0, 7'h4A, 0, 20, 0, 1'b0, 6'd0, 32'h0);
      send_cmd(6'd17, 32'h0000_0000, 48'h51_0000_0000_55, 7'h2A, 0, 0, 0, 1'b0, 6'd0, 32'h0);

      // Abort coincident with a request in IDLE must block acceptance.
      @(negedge clk);
      abort     = 1'b1;
      req_valid = 1'b1;
      req_index = 6'd8;
      #1;
      check("abort_gates_ready", 64'(req_ready), 64'd0);
      @(posedge clk);
      #1;
      check("abort_idle_busy", 64'(busy), 64'd0);
      @(negedge clk);
      abort     = 1'b0;
      req_valid = 1'b0;
      $display("idle abort with request: busy %0b", busy);

      send_cmd(6'd8,  32'h0000_01AA, 48'h0, 7'h00, 0, 0, 52, 1'b0, 6'd0, 32'h0);
      send_cmd(6'd0,  32'h0000_0000, 48'h40_0000_0000_95, 7'h4A, 0, 0, 0, 1'b0, 6'd0, 32'h0);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
